// File: rtl/mfu_accumulator_if.sv
// mfu_accumulator_if
//   Beat and result handshake bundle for the MFU accumulation stage.
//   Upstream beat channel : in_valid, in_ready, in_p, in_mode, in_last
//   Downstream result     : out_valid, out_ready, out_data, out_count,
//                           out_mode, ovf, mode_err
//   Modports: master = product source / result sink, slave = accumulator.
interface mfu_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [15:0]      in_p;
    logic [1:0]              in_mode;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [CNT_W-1:0]        out_count;
    logic [1:0]              out_mode;
    logic                    ovf;
    logic                    mode_err;

    modport master (
        output in_valid, in_p, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_mode, ovf, mode_err
    );

    modport slave (
        input  in_valid, in_p, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_mode, ovf, mode_err
    );
endinterface

// File: rtl/mfu_accumulator.sv
// mfu_accumulator
//   Signed per-tile accumulator behind the multi-precision multiplier of a
//   systolic PE. Sums 16-bit products over a tile and emits one ACC_W-bit
//   result per tile through a single output register with valid/ready.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - mfu_accumulator_if.slave: beat input (in_*) and result output
//          (out_*, ovf, mode_err)
// Build option:
//   MFU_ACC_SAT_EN - when defined, an overflowing sum clamps to the signed
//                    max/min of ACC_W; otherwise it wraps. ovf is set either way.
module mfu_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    mfu_accumulator_if.slave bus
);
    typedef enum logic {
        ST_FIRST,
        ST_ACCUM
    } state_t;

    localparam logic [1:0] MODE_NOOP = 2'b11;
`ifdef MFU_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Tile state
    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [1:0]              tile_mode, tile_mode_nxt;
    logic                    ovf_acc, ovf_nxt;
    logic                    err_acc, err_nxt;

    // Output register
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_data_q;
    logic [CNT_W-1:0]        out_count_q;
    logic [1:0]              out_mode_q;
    logic                    out_ovf_q;
    logic                    out_err_q;

    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_ovf;
    logic                    is_noop;
    logic                    mismatch;
    logic                    accept;
    logic [1:0]              res_mode;

    // The output register frees up in the same cycle it is drained, so a new
    // result can follow back-to-back with no bubble.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.ovf       = out_ovf_q;
    assign bus.mode_err  = out_err_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        tile_mode_nxt = tile_mode;
        ovf_nxt       = ovf_acc;
        err_nxt       = err_acc;

        p_ext    = {{(ACC_W-16){bus.in_p[15]}}, bus.in_p};
        sum      = acc + p_ext;
        // Same-sign operands producing an opposite-sign sum means overflow.
        sum_ovf  = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        is_noop  = (bus.in_mode == MODE_NOOP);
        mismatch = (state == ST_ACCUM) && !is_noop && (bus.in_mode != tile_mode);

        if (mismatch) begin
            err_nxt = 1'b1;
        end else if (!is_noop) begin
            if (state == ST_FIRST) begin
                state_nxt     = ST_ACCUM;
                tile_mode_nxt = bus.in_mode;
                acc_nxt       = p_ext;
            end else begin
                acc_nxt = sum;
                if (sum_ovf) begin
                    ovf_nxt = 1'b1;
`ifdef MFU_ACC_SAT_EN
                    // Sign of either operand tells which rail was crossed.
                    acc_nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
                end
            end
            cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
        end

        // A tile that never summed a beat reports NOOP as its mode.
        res_mode = (state_nxt == ST_FIRST) ? MODE_NOOP : tile_mode_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FIRST;
            acc         <= '0;
            cnt         <= '0;
            tile_mode   <= 2'b00;
            ovf_acc     <= 1'b0;
            err_acc     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_mode_q  <= 2'b00;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; later writes in this block win on purpose.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (bus.in_last) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_nxt;
                    out_count_q <= cnt_nxt;
                    out_mode_q  <= res_mode;
                    out_ovf_q   <= ovf_nxt;
                    out_err_q   <= err_nxt;
                    state       <= ST_FIRST;
                    acc         <= '0;
                    cnt         <= '0;
                    tile_mode   <= 2'b00;
                    ovf_acc     <= 1'b0;
                    err_acc     <= 1'b0;
                end else begin
                    state     <= state_nxt;
                    acc       <= acc_nxt;
                    cnt       <= cnt_nxt;
                    tile_mode <= tile_mode_nxt;
                    ovf_acc   <= ovf_nxt;
                    err_acc   <= err_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_mfu_accumulator.sv
// tb_mfu_accumulator
//   Scoreboard bench for mfu_accumulator at ACC_W=17 so the overflow
//   boundaries are reachable with 16-bit products. Expected tile results are
//   queued when the last beat is issued; a monitor pops and compares on each
//   output handshake.
module tb_mfu_accumulator;
    localparam int ACC_W = 17;
    localparam int CNT_W = 16;

`ifdef MFU_ACC_SAT_EN
    localparam longint OVF_POS  = 65535;
    localparam longint OVF_NEG  = -65536;
    localparam longint OVF_CONT = 65534;
`else
    localparam longint OVF_POS  = -32771;
    localparam longint OVF_NEG  = 32768;
    localparam longint OVF_CONT = -32772;
`endif

    typedef struct {
        longint     data;
        longint     count;
        logic [1:0] mode;
        logic       ovf;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    mfu_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mfu_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_tile(input longint d, input longint c, input logic [1:0] m,
                               input logic o, input logic e);
        exp_t x;
        x.data = d; x.count = c; x.mode = m; x.ovf = o; x.err = e;
        exp_q.push_back(x);
        n_push++;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send(input logic signed [15:0] p, input logic [1:0] m, input logic last);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_p     = p;
        bus.in_mode  = m;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck at 0 for beat %0d", p);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_out_data"},  longint'($signed(bus.out_data)), 0);
        check({tag, "_out_count"}, longint'(bus.out_count), 0);
        check({tag, "_out_mode"},  longint'(bus.out_mode), 0);
        check({tag, "_ovf"},       longint'(bus.ovf), 0);
        check({tag, "_mode_err"},  longint'(bus.mode_err), 0);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rise.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got data %0d, required no result",
                         $signed(bus.out_data));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_pop++;
                check($sformatf("res%0d_data", n_pop),  longint'($signed(bus.out_data)), e.data);
                check($sformatf("res%0d_count", n_pop), longint'(bus.out_count), e.count);
                check($sformatf("res%0d_mode", n_pop),  longint'(bus.out_mode), longint'(e.mode));
                check($sformatf("res%0d_ovf", n_pop),   longint'(bus.ovf), longint'(e.ovf));
                check($sformatf("res%0d_err", n_pop),   longint'(bus.mode_err), longint'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_p      = '0;
        bus.in_mode   = 2'b00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_in_ready", longint'(bus.in_ready), 1);
        rst = 1'b0;

        // Basic 8x8 tile with one-cycle latency.
        expect_tile(-16234, 3, 2'b00, 1'b0, 1'b0);
        send(-100, 2'b00, 1'b0);
        send(250, 2'b00, 1'b0);
        check("basic_no_early_valid", longint'(bus.out_valid), 0);
        send(-16384, 2'b00, 1'b1);
        check("basic_valid_after_1", longint'(bus.out_valid), 1);
        @(posedge clk); #1;
        check("basic_valid_dropped", longint'(bus.out_valid), 0);

        // Back-pressure, then back-to-back tiles with no bubble.
        bus.out_ready = 1'b0;
        expect_tile(5, 1, 2'b00, 1'b0, 1'b0);
        send(5, 2'b00, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_p     = 16'sd7;
        bus.in_mode  = 2'b00;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready_c%0d", i), longint'(bus.in_ready), 0);
            check($sformatf("bp_hold_data_c%0d", i), longint'($signed(bus.out_data)), 5);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(7, 2'b00, 1'b0);
        expect_tile(16, 2, 2'b00, 1'b0, 1'b0);
        send(9, 2'b00, 1'b1);
        expect_tile(1, 1, 2'b00, 1'b0, 1'b0);
        send(1, 2'b00, 1'b1);
        check("nobubble_valid", longint'(bus.out_valid), 1);
        check("nobubble_data", longint'($signed(bus.out_data)), 1);
        @(posedge clk); #1;

        // Mode mismatch and NOOP inside a 4x4 tile.
        expect_tile(12, 2, 2'b01, 1'b0, 1'b1);
        send(10, 2'b01, 1'b0);
        send(3, 2'b10, 1'b0);
        send(99, 2'b11, 1'b0);
        send(2, 2'b01, 1'b1);

        // Overflow at ACC_W=17, then a clean tile showing ovf cleared.
        expect_tile(OVF_POS, 3, 2'b00, 1'b1, 1'b0);
        send(32767, 2'b00, 1'b0);
        send(32767, 2'b00, 1'b0);
        send(32767, 2'b00, 1'b1);
        expect_tile(1, 1, 2'b00, 1'b0, 1'b0);
        send(1, 2'b00, 1'b1);
        // Exactly the negative rail: no overflow.
        expect_tile(-65536, 2, 2'b00, 1'b0, 1'b0);
        send(-32768, 2'b00, 1'b0);
        send(-32768, 2'b00, 1'b1);
        // Past the negative rail.
        expect_tile(OVF_NEG, 3, 2'b00, 1'b1, 1'b0);
        send(-32768, 2'b00, 1'b0);
        send(-32768, 2'b00, 1'b0);
        send(-32768, 2'b00, 1'b1);
        // Accumulation continues from the clamped or wrapped value.
        expect_tile(OVF_CONT, 4, 2'b00, 1'b1, 1'b0);
        send(32767, 2'b00, 1'b0);
        send(32767, 2'b00, 1'b0);
        send(32767, 2'b00, 1'b0);
        send(-1, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-tile discards the partial sum.
        send(50, 2'b00, 1'b0);
        send(60, 2'b00, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrst");
        rst = 1'b0;
        expect_tile(4, 1, 2'b00, 1'b0, 1'b0);
        send(4, 2'b00, 1'b1);
        @(posedge clk); #1;

        // NOOP-only tile.
        expect_tile(0, 0, 2'b11, 1'b0, 1'b0);
        send(0, 2'b11, 1'b1);
        check("noop_valid", longint'(bus.out_valid), 1);
        @(posedge clk); #1;
        check("noop_one_handshake", longint'(bus.out_valid), 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", longint'(exp_q.size()), 0);
        check("results_delivered", longint'(n_pop), longint'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
